// File: rtl/scan_signature_analyzer.sv
// scan_signature_analyzer: serial-input signature register (SISR) compacting
// the scan-out stream of the circuit under test during BIST.
// Polynomial x^16+x^15+x^13+x^4+1 (taps 15,14,12,3), same as the pattern LFSR.
// Optional macro SIG_FAIL_COUNT_EN adds a saturating failed-session counter.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high; returns the block to IDLE
//   start      - single-cycle pulse; (re)starts a session
//   mode       - compaction enable; high = absorb scan_in this cycle
//   scan_in    - serial scan-out bit from the CUT
//   busy       - high while a session is running
//   done       - session complete
//   pass       - signature matched GOLDEN; only meaningful while done=1
//   signature  - current signature register contents
//   fail_count - (SIG_FAIL_COUNT_EN only) sessions that ended with pass=0
module scan_signature_analyzer #(
    parameter logic [15:0] SEED      = 16'h0000,
    parameter logic [15:0] GOLDEN    = 16'h0000,
    parameter int          BIT_COUNT = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic        scan_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
`ifdef SIG_FAIL_COUNT_EN
    output logic [7:0]  fail_count,
`endif
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value at which the incoming bit is the last one of the session.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_COUNT - 1);

    state_t             state, state_n;
    logic [15:0]        sig, sig_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               pass_q, pass_n;
    logic               fail_event;

    logic               fb;
    logic [15:0]        next_sig;

    assign fb       = sig[15] ^ sig[14] ^ sig[12] ^ sig[3] ^ scan_in;
    assign next_sig = {sig[14:0], fb};

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sig    <= SEED;
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_n;
            sig    <= sig_n;
            cnt    <= cnt_n;
            pass_q <= pass_n;
        end
    end

    always_comb begin
        state_n    = state;
        sig_n      = sig;
        cnt_n      = cnt;
        pass_n     = pass_q;
        fail_event = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    sig_n   = SEED;
                    cnt_n   = '0;
                    pass_n  = 1'b0;
                end
            end

            RUN: begin
                // A start here aborts the session; the bit on scan_in this
                // cycle is dropped and a terminal condition is overridden.
                if (start) begin
                    sig_n  = SEED;
                    cnt_n  = '0;
                    pass_n = 1'b0;
                end else if (mode) begin
                    sig_n = next_sig;
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        // Compare the freshly updated signature so done and
                        // pass rise on the edge that absorbs the final bit.
                        state_n    = DONE;
                        pass_n     = (next_sig == GOLDEN);
                        fail_event = (next_sig != GOLDEN);
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_n = RUN;
                    sig_n   = SEED;
                    cnt_n   = '0;
                    pass_n  = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
                sig_n   = SEED;
                cnt_n   = '0;
                pass_n  = 1'b0;
            end
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = pass_q & (state == DONE);
    assign signature = sig;

`ifdef SIG_FAIL_COUNT_EN
    // Survives start; only reset clears it. Saturates rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            fail_count <= 8'h00;
        end else if (fail_event && (fail_count != 8'hFF)) begin
            fail_count <= fail_count + 8'h01;
        end
    end
`else
    // Terminal-mismatch strobe has no consumer in this build.
    logic unused_fail_event;
    assign unused_fail_event = fail_event;
`endif

endmodule

// File: tb/tb_scan_signature_analyzer.sv
// Directed bench for scan_signature_analyzer (BIT_COUNT=4, SEED=0, GOLDEN=0008).
// Each step drives inputs, pushes the hand-derived expected outputs to a
// queue, and pops/compares them one time unit after the following rising edge.
module tb_scan_signature_analyzer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic        scan_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
`ifdef SIG_FAIL_COUNT_EN
    logic [7:0]  fail_count;
`endif

    int tests = 0;
    int fails = 0;
    int step_no = 0;

    typedef struct packed {
        logic [15:0] sig;
        logic        busy;
        logic        done;
        logic        pass;
    } exp_t;

    exp_t sb[$];

    scan_signature_analyzer #(
        .SEED      (16'h0000),
        .GOLDEN    (16'h0008),
        .BIT_COUNT (4),
        .CNT_W     (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .scan_in   (scan_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
`ifdef SIG_FAIL_COUNT_EN
        .fail_count(fail_count),
`endif
        .signature (signature)
    );

    always #5 clock = ~clock;

    // One clock: drive inputs, record expectation, compare after the edge.
    task automatic step(input logic rs, input logic st, input logic md,
                        input logic si, input logic [15:0] es,
                        input logic eb, input logic ed, input logic ep);
        exp_t e;
        reset   = rs;
        start   = st;
        mode    = md;
        scan_in = si;
        sb.push_back({es, eb, ed, ep});
        @(posedge clock);
        #1;
        step_no++;
        e = sb.pop_front();
        tests++;
        assert (signature === e.sig) else begin
            fails++;
            $error("FAIL step%0d signature: got %h expected %h", step_no, signature, e.sig);
        end
        tests++;
        assert (busy === e.busy) else begin
            fails++;
            $error("FAIL step%0d busy: got %b expected %b", step_no, busy, e.busy);
        end
        tests++;
        assert (done === e.done) else begin
            fails++;
            $error("FAIL step%0d done: got %b expected %b", step_no, done, e.done);
        end
        tests++;
        assert (pass === e.pass) else begin
            fails++;
            $error("FAIL step%0d pass: got %b expected %b", step_no, pass, e.pass);
        end
    endtask

`ifdef SIG_FAIL_COUNT_EN
    task automatic check_fc(input logic [7:0] exp_fc);
        tests++;
        assert (fail_count === exp_fc) else begin
            fails++;
            $error("FAIL fail_count: got %0d expected %0d", fail_count, exp_fc);
        end
    endtask

    // Full failing session: scan_in all ones gives 000F != 0008.
    task automatic fail_session();
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0003, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0007, 1, 0, 0);
        step(0, 0, 1, 1, 16'h000F, 0, 1, 0);
    endtask
`endif

    initial begin
        // Reset, then ten idle cycles; mode/scan_in active must be ignored.
        step(1, 0, 0, 0, 16'h0000, 0, 0, 0);
`ifdef SIG_FAIL_COUNT_EN
        check_fc(8'd0);
`endif
        for (int i = 0; i < 10; i++)
            step(0, 0, 1, 1, 16'h0000, 0, 0, 0);

        // Passing session 1,0,0,0; the start-cycle bit is not compacted.
        step(0, 1, 1, 1, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0008, 0, 1, 1);
        step(0, 0, 1, 1, 16'h0008, 0, 1, 1);   // DONE holds, mode ignored

        // Failing session 1,1,1,1; start from DONE clears done/pass.
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0003, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0007, 1, 0, 0);
        step(0, 0, 1, 1, 16'h000F, 0, 1, 0);
        step(0, 0, 0, 0, 16'h000F, 0, 1, 0);

        // Stall of three cycles between bits 2 and 3.
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 1, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0008, 0, 1, 1);

        // Abort after two bits, then a full passing session.
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 1, 1, 1, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0008, 0, 1, 1);

        // start coincident with the terminal bit: start wins, no done.
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 1, 1, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0008, 0, 1, 1);

        // Reset mid-RUN discards the partial signature.
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(1, 0, 1, 1, 16'h0000, 0, 0, 0);
        step(0, 0, 1, 1, 16'h0000, 0, 0, 0);

`ifdef SIG_FAIL_COUNT_EN
        check_fc(8'd0);
        fail_session();
        check_fc(8'd1);
        fail_session();
        fail_session();
        check_fc(8'd3);
        step(0, 1, 0, 0, 16'h0000, 1, 0, 0);
        step(0, 0, 1, 1, 16'h0001, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0002, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0004, 1, 0, 0);
        step(0, 0, 1, 0, 16'h0008, 0, 1, 1);
        check_fc(8'd3);
        step(1, 0, 0, 0, 16'h0000, 0, 0, 0);
        check_fc(8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_signature_analyzer.md
Name: scan_signature_analyzer

Overview:
Serial-input signature register (SISR) that compacts the scan-out stream of the circuit under test during BIST.
- Sits at the scan-chain output, opposite the LFSR pattern generator.
- Uses the same 16-bit polynomial x^16+x^15+x^13+x^4+1 (taps 15,14,12,3).
- Counts compacted bits and, after a programmed length, compares the signature against a golden value.
- Reports done/pass to the BIST controller.

Parameters:
- SEED, 16'h0000: signature value loaded on start.
- GOLDEN, 16'h0000: expected final signature.
- BIT_COUNT, 1024: number of scan bits compacted per session; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of the bit counter.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  single-cycle pulse; (re)starts a session.
- mode  input  1  compaction enable; high = absorb scan_in this cycle (same meaning as generator mode).
- scan_in  input  1  serial scan-out bit from the CUT.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; session complete.
- pass  output  1  signature matched GOLDEN; valid only while done=1, else 0.
- signature  output  16  current signature register contents.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. Reset wins over every other input.
- Reset values: state=IDLE, sig=SEED, cnt=0, busy=0, done=0, pass=0.
- Feedback bit: fb = sig[15]^sig[14]^sig[12]^sig[3]^scan_in (plain XOR, no inversion).
- Signature update: next_sig = {sig[14:0], fb}.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; sig<=SEED, cnt<=0.
  - mode is ignored; sig holds.
- RUN:
  - busy=1.
  - mode=1: sig<=next_sig, cnt<=cnt+1.
  - mode=0: sig and cnt hold (stall is permitted at any point).
- Terminal condition: mode=1 and cnt==BIT_COUNT-1. On that edge:
  - state<=DONE;
  - sig<=next_sig;
  - done<=1;
  - pass<=(next_sig==GOLDEN). The comparison uses the updated value, so there is no extra cycle.
- Latency: done/pass rise on the same edge that absorbs the final bit.
- DONE:
  - sig, done and pass hold; mode is ignored.
  - start -> RUN with reload (sig<=SEED, cnt<=0, done<=0, pass<=0).
- start during RUN: abort the current session and restart (reload SEED, cnt=0). The bit presented that cycle is NOT compacted.
- start and the terminal condition in the same cycle: start wins; no done is produced.
- Reset mid-RUN: IDLE next edge; partial signature discarded (sig=SEED).
- BIT_COUNT=1: a single mode=1 cycle in RUN finishes the session.
- Counter never wraps in RUN because the terminal condition exits first.

Optional Feature:
Macro SIG_FAIL_COUNT_EN.
- Defined:
  - Adds output fail_count[7:0], reset to 0.
  - Increments on each edge where the block enters DONE with pass=0.
  - Saturates at 8'hFF.
  - Not cleared by start, only by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: with start=0 for 10 cycles -> busy=0, done=0, pass=0, signature=16'h0000.
- BIT_COUNT=4, SEED=0, GOLDEN=16'h0008: start, then mode=1 with scan_in 1,0,0,0 -> signature 0001,0002,0004,0008; done=1, pass=1 on 4th edge.
- Same setup, scan_in 1,1,1,1 -> signature 0001,0003,0007,000F; done=1, pass=0.
- Stall: same as scenario 2 but mode=0 for 3 cycles between bits 2 and 3 -> signature holds 0002 during the stall; final 0008, pass=1; busy high throughout.
- Abort/reset:
  - start pulse after 2 bits -> signature back to 0000, cnt restarts; 4 more bits 1,0,0,0 -> 0008, pass=1.
  - Separately, reset after 2 bits -> IDLE, busy=0.
- With SIG_FAIL_COUNT_EN: run 3 failing sessions (scan_in all 1, GOLDEN=0008) -> fail_count=3; a passing session leaves it at 3; reset -> 0.
